// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer.
// Carries PC, instruction and control bundle; adds flush, freeze and stall/flush statistics.
module pipe_stage_skid #(
  parameter int PC_W   = 12,
  parameter int INS_W  = 19,
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              hold,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INS_W-1:0]  in_ins,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INS_W-1:0]  out_ins,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INS_W-1:0]  ins;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  occ_e             occ, occNext;
  entry_t           mainQ, mainD, skidQ, skidD, inEntry;
  logic             accept, fire, stallInc, flushInc;
  logic [CNT_W-1:0] stallCnt, flushCnt;

  assign inEntry  = '{pc: in_pc, ins: in_ins, ctrl: in_ctrl};
  assign in_ready = ~hold & (occ != FULL);
  assign accept   = in_valid & in_ready & ~flush;
  assign fire     = out_valid & out_ready & ~hold;
  assign stallInc = in_valid & ~in_ready & ~flush;
  assign flushInc = flush & (occ != EMPTY);

  // Hold needs no branch of its own: it already forces accept and fire low.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
    occNext = occ;
    mainD   = mainQ;
    skidD   = skidQ;
    if (flush) begin
      occNext = EMPTY;
      mainD   = '0;
      skidD   = '0;
    end else begin
      unique case (occ)
        EMPTY: begin
          if (accept) begin
            mainD   = inEntry;
            occNext = ONE;
          end
        end
        ONE: begin
          if (fire && accept) begin
            mainD = inEntry;
          end else if (fire) begin
            mainD   = '0;
            occNext = EMPTY;
          end else if (accept) begin
            skidD   = inEntry;
            occNext = FULL;
          end
        end
        FULL: begin
          if (fire) begin
            mainD   = skidQ;
            skidD   = '0;
            occNext = ONE;
          end
        end
        default: begin
          occNext = EMPTY;
          mainD   = '0;
          skidD   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      // NOTE: entry storage is reset too, because out_* must read as a zero bubble after reset.
      occ      <= EMPTY;
      mainQ    <= '0;
      skidQ    <= '0;
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      occ   <= occNext;
      mainQ <= mainD;
      skidQ <= skidD;
      if (stallInc && (stallCnt != '1)) stallCnt <= stallCnt + CNT_W'(1);
      if (flushInc && (flushCnt != '1)) flushCnt <= flushCnt + CNT_W'(1);
    end
  end

  // Main entry is zeroed on every path into EMPTY, so the outputs are a no-op bubble when invalid.
  assign out_valid = (occ != EMPTY);
  assign out_pc    = mainQ.pc;
  assign out_ins   = mainQ.ins;
  assign out_ctrl  = mainQ.ctrl;
  assign occupancy = occ;
  assign stall_cnt = stallCnt;
  assign flush_cnt = flushCnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: a negedge monitor scoreboards every transfer
// while per-scenario tasks drive stimulus and check state at scenario boundaries.
module tb_pipe_stage_skid;

  typedef struct {
    logic [11:0] pc;
    logic [18:0] ins;
    logic [11:0] ctrl;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        hold = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [11:0] in_pc = '0;
  logic [18:0] in_ins = '0;
  logic [11:0] in_ctrl = '0;
  logic        in_ready, out_valid;
  logic [11:0] out_pc, out_ctrl;
  logic [18:0] out_ins;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt, flush_cnt;

  logic        in_ready2, out_valid2;
  logic [11:0] out_pc2, out_ctrl2;
  logic [18:0] out_ins2;
  logic [1:0]  occupancy2;
  logic [1:0]  stall_cnt2, flush_cnt2;

  int     passCnt = 0;
  int     checkCnt = 0;
  int     popCnt = 0;
  bit     started = 1'b0;
  entry_t sb[$];

  always #5 clk = ~clk;

  pipe_stage_skid dut (
    .clk(clk), .rst(rst), .flush(flush), .hold(hold),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_ins(in_ins), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_ins(out_ins), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_stage_skid #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .hold(hold),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_pc(in_pc), .in_ins(in_ins), .in_ctrl(in_ctrl),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_pc(out_pc2), .out_ins(out_ins2), .out_ctrl(out_ctrl2),
    .occupancy(occupancy2), .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  // Scoreboard: the queue is the reference model of what the stage holds.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else if (started) begin
      logic   expReady;
      entry_t e;
      expReady = !hold && (sb.size() != 2);
      checkCnt++;
      if (occupancy !== 2'(sb.size())) $display("FAIL mon_occupancy got %0d expected %0d", occupancy, sb.size());
      else passCnt++;
      checkCnt++;
      if (in_ready !== expReady) $display("FAIL mon_in_ready got %b expected %b", in_ready, expReady);
      else passCnt++;
      checkCnt++;
      if (out_valid !== (sb.size() != 0)) $display("FAIL mon_out_valid got %b expected %b", out_valid, sb.size() != 0);
      else passCnt++;
      if (!out_valid) begin
        checkCnt++;
        if ({out_pc, out_ins, out_ctrl} !== '0)
          $display("FAIL mon_bubble got pc=%h ins=%h ctrl=%h expected all 0", out_pc, out_ins, out_ctrl);
        else passCnt++;
      end
      if (flush) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready && !hold) begin
          checkCnt++;
          if (sb.size() == 0) begin
            $display("FAIL mon_fire_empty got pc=%h expected no entry", out_pc);
          end else begin
            e = sb.pop_front();
            popCnt++;
            if (out_pc !== e.pc || out_ins !== e.ins || out_ctrl !== e.ctrl)
              $display("FAIL mon_entry got pc=%h ins=%h ctrl=%h expected pc=%h ins=%h ctrl=%h",
                       out_pc, out_ins, out_ctrl, e.pc, e.ins, e.ctrl);
            else passCnt++;
          end
        end
        if (in_valid && expReady) sb.push_back('{pc: in_pc, ins: in_ins, ctrl: in_ctrl});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_entry(input logic [11:0] pc);
    in_pc   = pc;
    in_ins  = 19'(32'h10000 + 32'(pc) * 3);
    in_ctrl = 12'(12'h0A5 ^ pc);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checkCnt++;
    if ({out_valid, occupancy, out_pc, out_ins, out_ctrl} !== '0)
      $display("FAIL reset_outputs got v=%b occ=%0d pc=%h expected 0", out_valid, occupancy, out_pc);
    else passCnt++;
    checkCnt++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0)
      $display("FAIL reset_counters got stall=%0d flush=%0d expected 0", stall_cnt, flush_cnt);
    else passCnt++;
    rst = 1'b0;
    started = 1'b1;
    #1;
    checkCnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b expected 1", in_ready);
    else passCnt++;
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      drive_entry(12'(i));
      step();
      checkCnt++;
      if (out_pc !== 12'(i) || out_valid !== 1'b1 || occupancy !== 2'd1)
        $display("FAIL stream_out got pc=%h v=%b occ=%0d expected pc=%h v=1 occ=1", out_pc, out_valid, occupancy, 12'(i));
      else passCnt++;
    end
    in_valid = 1'b0;
    step();
    checkCnt++;
    if (stall_cnt !== 16'd0 || occupancy !== 2'd0)
      $display("FAIL stream_end got stall=%0d occ=%0d expected 0 0", stall_cnt, occupancy);
    else passCnt++;
  endtask

  task automatic test_back_to_back();
    int next = 0;
    int pops0;
    pops0 = popCnt;
    for (int cyc = 0; cyc < 8; cyc++) begin
      in_valid  = (next < 5);
      drive_entry(12'(32'h10 + next));
      out_ready = (cyc >= 3);
      #1;
      if (in_valid && in_ready) next++;
      step();
      if (cyc == 2) begin
        checkCnt++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0)
          $display("FAIL bp_full got occ=%0d rdy=%b expected 2 0", occupancy, in_ready);
        else passCnt++;
      end
    end
    in_valid = 1'b0;
    checkCnt++;
    if (stall_cnt !== 16'd2) $display("FAIL bp_stall_cnt got %0d expected 2", stall_cnt);
    else passCnt++;
    checkCnt++;
    if (popCnt - pops0 !== 5 || occupancy !== 2'd0)
      $display("FAIL bp_drain got pops=%0d occ=%0d expected 5 0", popCnt - pops0, occupancy);
    else passCnt++;
  endtask

  task automatic test_flush();
    logic [15:0] f0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive_entry(12'h020);
    step();
    drive_entry(12'h021);
    step();
    f0 = flush_cnt;
    flush = 1'b1;
    drive_entry(12'h022);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    checkCnt++;
    if (out_valid !== 1'b0 || out_ctrl !== 12'h000 || occupancy !== 2'd0 || in_ready !== 1'b1)
      $display("FAIL flush_full got v=%b ctrl=%h occ=%0d rdy=%b expected 0 000 0 1", out_valid, out_ctrl, occupancy, in_ready);
    else passCnt++;
    checkCnt++;
    if (flush_cnt !== f0 + 16'd1) $display("FAIL flush_cnt_inc got %0d expected %0d", flush_cnt, f0 + 16'd1);
    else passCnt++;
    flush = 1'b1;
    step();
    flush = 1'b0;
    checkCnt++;
    if (flush_cnt !== f0 + 16'd1) $display("FAIL flush_cnt_empty got %0d expected %0d", flush_cnt, f0 + 16'd1);
    else passCnt++;
  endtask

  task automatic test_hold();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive_entry(12'h055);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    hold      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checkCnt++;
      if (out_pc !== 12'h055 || in_ready !== 1'b0 || occupancy !== 2'd1)
        $display("FAIL hold_stable got pc=%h rdy=%b occ=%0d expected 055 0 1", out_pc, in_ready, occupancy);
      else passCnt++;
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    hold  = 1'b0;
    checkCnt++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0)
      $display("FAIL hold_flush got occ=%0d v=%b expected 0 0", occupancy, out_valid);
    else passCnt++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive_entry(12'h030);
    step();
    drive_entry(12'h031);
    step();
    step();
    checkCnt++;
    if (occupancy !== 2'd2) $display("FAIL rstmid_pre got occ=%0d expected 2", occupancy);
    else passCnt++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    checkCnt++;
    if ({out_valid, occupancy, out_pc, out_ins, out_ctrl, stall_cnt, flush_cnt} !== '0)
      $display("FAIL rstmid_out got v=%b occ=%0d pc=%h stall=%0d flush=%0d expected all 0",
               out_valid, occupancy, out_pc, stall_cnt, flush_cnt);
    else passCnt++;
  endtask

  task automatic test_saturation();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive_entry(12'h040);
    step();
    drive_entry(12'h041);
    step();
    drive_entry(12'h042);
    for (int i = 0; i < 5; i++) step();
    checkCnt++;
    if (stall_cnt2 !== 2'd3) $display("FAIL sat_stall_cnt got %0d expected 3", stall_cnt2);
    else passCnt++;
    checkCnt++;
    if (stall_cnt !== 16'd5) $display("FAIL sat_wide_stall_cnt got %0d expected 5", stall_cnt);
    else passCnt++;
    in_valid = 1'b0;
    flush    = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_to_back();
    test_flush();
    test_hold();
    test_reset_mid();
    test_saturation();
    step();
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
